// File: rtl/connect_pkg.sv
// Shared types and constants for the registered point-to-point connection slice.
package connect_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_t;

  localparam int unsigned BEATS_W = 32;

endpackage

// File: rtl/connect_slice.sv
// Two-entry skid-buffered valid/ready connection; every output is driven from flops only.
module connect_slice
  import connect_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         occupancy,
  output logic [BEATS_W-1:0] beats
);

  slice_state_t       state_q, state_d;
  logic [WIDTH-1:0]   main_q, skid_q;
  logic               running_q;
  logic [BEATS_W-1:0] beats_q;

  logic accept, deliver;
  logic load_main_in, load_main_skid, load_skid;

  assign in_ready  = running_q && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign beats     = beats_q;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q    <= '0;
      skid_q    <= '0;
      running_q <= 1'b0;
      beats_q   <= '0;
    end else begin
      running_q <= 1'b1;
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
      if (deliver)             beats_q <= beats_q + BEATS_W'(1);
    end
  end

endmodule

// File: doc/connect_slice.md
# connect_slice

Registered, flow-controlled point-to-point connection: the sequential counterpart of the plain net connector. It carries a WIDTH-bit data stream from a producer to a consumer with valid/ready handshaking. A two-entry skid buffer breaks every combinational path between the two ends (data, valid and ready). It is inserted between generated modules wherever a wire connection would create a long or combinational ready path.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- CLK  in  1  sole clock; all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  producer payload
- in_valid  in  1  producer offers in_data this cycle
- in_ready  out  1  slice accepts this cycle; registered, no combinational path from any input
- out_data  out  WIDTH  consumer payload; registered
- out_valid  out  1  out_data valid; registered
- out_ready  in  1  consumer accepts this cycle
- occupancy  out  2  entries held (0, 1, 2); registered
- beats  out  32  count of completed output transfers; wraps

## Operation
- Accept: in_valid & in_ready at a rising edge. Deliver: out_valid & out_ready at a rising edge.
- Storage: main register (drives out_data) plus skid register.
- States:
  - EMPTY: nothing held.
  - ONE: main holds data.
  - TWO: main and skid both hold data.
- EMPTY: accept → ONE, main ← in_data.
- ONE:
  - accept only → TWO, skid ← in_data.
  - deliver only → EMPTY.
  - accept and deliver → ONE, main ← in_data.
- TWO: in_ready=0, so no accept.
  - deliver → ONE, main ← skid.
  - otherwise hold.
- Outputs derived from state:
  - out_valid = (state≠EMPTY).
  - in_ready = (state≠TWO) outside reset.
  - occupancy = 0/1/2 for EMPTY/ONE/TWO.
- Ordering: strict FIFO; no drop, duplication or reorder.
- beats increments by 1 on every deliver; 32'hFFFF_FFFF → 0.
- in_valid while in_ready=0: ignored, producer must hold. in_data is sampled only on accept.
- Protocol rule on the producer: once in_valid is high, it stays high with stable in_data until accepted. The slice obeys the same rule on its output.

## Timing
- Reset (RST_N low, asynchronous, independent of CLK):
  - state=EMPTY, out_valid=0, in_ready=0, occupancy=0, out_data=0, skid=0, beats=0.
- in_ready rises on the first rising CLK edge after RST_N deasserts. It is tracked by a registered "out of reset" flag.
- Reset mid-operation: all held data is discarded immediately. No partial output is presented after reset.
- Latency: data accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1) when the slice was EMPTY.
- Throughput: one beat per cycle sustained while out_ready=1.
- Full: a skid entry is used only when the consumer stalls. in_ready falls the cycle after the second entry is filled. It rises the cycle after a deliver from TWO.
- Simultaneous accept+deliver in ONE: occupancy stays 1, beats increments.
- No path exists from out_ready to in_ready, or from in_valid/in_data to out_*, within a cycle.

## Structure
- Shared package connect_pkg:
  - slice_state_t (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
  - BEATS_W=32 constant.
- Single flat module, no sub-modules. The state register, two data registers, reset flag and beats counter fit in one file.
- The encoding of TWO=2'd2 lets occupancy be driven directly from state.

## Test plan
- Reset release:
  - Stimulus: hold RST_N=0 for 3 cycles with in_valid=1; then release.
  - Response: in_ready=0, out_valid=0, occupancy=0, beats=0 throughout reset. in_ready=1 exactly one edge after release. No beat is accepted before that edge.
- Streaming:
  - Stimulus: out_ready=1; send 0x00000001..0x00000010 back-to-back.
  - Response: out_data emits the same 16 values in order, first one cycle after the first accept. occupancy stays ≤1. beats=16.
- Backpressure fill:
  - Stimulus: out_ready=0; offer 0xA, 0xB, 0xC.
  - Response: 0xA and 0xB accepted; occupancy=2; in_ready=0; 0xC held off.
  - Stimulus: raise out_ready.
  - Response: delivers 0xA, 0xB, 0xC in order, one per cycle.
- Simultaneous accept/deliver:
  - Stimulus: in ONE holding 0x5; in_valid=1 (0x6) and out_ready=1 in the same cycle.
  - Response: next cycle out_data=0x6, occupancy=1, beats+1.
- Counter wrap:
  - Stimulus: force beats to 0xFFFFFFFE; deliver 3 beats.
  - Response: beats reads 0xFFFFFFFF, 0x0, 0x1.
- Async reset mid-stream:
  - Stimulus: assert RST_N low between clock edges while in TWO.
  - Response: out_valid and occupancy go to 0 without a CLK edge. After release the first delivered value is the first value offered after release.
